// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port between two producers
// Optional per-producer accepted-beat counters are enabled by defining ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          fifo_full,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  output logic [1:0]    grant,
  output logic          busy,
  output logic [7:0]    acc0,
  output logic [7:0]    acc1
);

  localparam int            BW   = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  // Owner-relative view of the two request lines, so one code path serves OWN0 and OWN1.
  logic own1;
  logic own_valid;
  logic oth_valid;

  assign own1      = (state_q == OWN1);
  assign own_valid = own1 ? req1_valid : req0_valid;
  assign oth_valid = own1 ? req0_valid : req1_valid;

  assign grant = {state_q == OWN1, state_q == OWN0};
  assign busy  = (state_q != IDLE);

  // State, priority pointer and burst counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state and output decode; outputs come from state so reset kills the write strobe at once.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    bcnt_d       = bcnt_q;
    fifo_wr_en   = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    fifo_wr_data = '0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          state_d = ptr_q ? OWN1 : OWN0;
        end else if (req0_valid) begin
          state_d = OWN0;
        end else if (req1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        fifo_wr_en   = own_valid & ~fifo_full;
        req0_ready   = fifo_wr_en & ~own1;
        req1_ready   = fifo_wr_en & own1;
        fifo_wr_data = own1 ? req1_data : req0_data;
        if (fifo_wr_en) begin
          bcnt_d = bcnt_q + 1'b1;
        end
        // A full FIFO with the owner still valid freezes everything; only burst end or idle owner releases.
        if ((fifo_wr_en && (bcnt_q == LAST)) || !own_valid) begin
          ptr_d  = ~own1;
          bcnt_d = '0;
          if (oth_valid) begin
            state_d = own1 ? OWN0 : OWN1;
          end else if (own_valid) begin
            state_d = state_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ARB_STATS_EN
  logic [7:0] acc0_q;
  logic [7:0] acc1_q;

  // Saturating accepted-beat counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0_q <= 8'd0;
      acc1_q <= 8'd0;
    end else begin
      if (req0_ready && (acc0_q != 8'hFF)) begin
        acc0_q <= acc0_q + 8'd1;
      end
      if (req1_ready && (acc1_q != 8'hFF)) begin
        acc1_q <= acc1_q + 8'd1;
      end
    end
  end

  assign acc0 = acc0_q;
  assign acc1 = acc1_q;
`else
  assign acc0 = 8'd0;
  assign acc1 = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       fifo_full;
  logic       fifo_wr_en;
  logic [7:0] fifo_wr_data;
  logic [1:0] grant;
  logic       busy;
  logic [7:0] acc0;
  logic [7:0] acc1;

  int total;
  int bad;
  int beats;

  fifo_wr_arbiter #(.DW(8), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant        (grant),
    .busy         (busy),
    .acc0         (acc0),
    .acc1         (acc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks are made a further 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 8'h00;
    req1_data  = 8'h00;
    fifo_full  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset held with both producers valid: everything stays 0.
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'hAA;
    req1_data  = 8'hBB;
    fifo_full  = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_acc0", 32'(acc0), 32'd0);
    chk("rst_acc1", 32'(acc1), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", 32'(grant), 32'd0);
    tick();
    #1;
    chk("post_rst_grant", 32'(grant), 32'd1);
    chk("post_rst_first_beat", 32'(fifo_wr_data), 32'hAA);

    // Producer 0 alone streams 10 beats: 4+4+2 with no bubble at re-grant.
    do_reset();
    tick();
    req0_valid = 1'b1;
    req0_data  = 8'h10;
    #1;
    chk("s0_idle_wr_en", 32'(fifo_wr_en), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      req0_data = 8'(8'h10 + i);
      #1;
      chk($sformatf("s0_grant_%0d", i), 32'(grant), 32'd1);
      chk($sformatf("s0_wr_en_%0d", i), 32'(fifo_wr_en), 32'd1);
      chk($sformatf("s0_data_%0d", i), 32'(fifo_wr_data), 32'(8'h10 + i));
    end
    tick();
    req0_valid = 1'b0;
    #1;
    chk("s0_drop_wr_en", 32'(fifo_wr_en), 32'd0);
    tick();
    #1;
    chk("s0_idle_grant", 32'(grant), 32'd0);
`ifdef ARB_STATS_EN
    chk("s0_acc0", 32'(acc0), 32'd10);
`else
    chk("s0_acc0", 32'(acc0), 32'd0);
`endif

    // Both producers continuously valid: bursts of 4 alternate starting with producer 0.
    do_reset();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rr_idle_grant", 32'(grant), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      req0_data = 8'(8'h20 + k);
      req1_data = 8'(8'h30 + k);
      #1;
      chk($sformatf("rr_grant_%0d", k), 32'(grant), ((k / 4) % 2 == 1) ? 32'd2 : 32'd1);
      chk($sformatf("rr_wr_en_%0d", k), 32'(fifo_wr_en), 32'd1);
      chk($sformatf("rr_data_%0d", k), 32'(fifo_wr_data),
          ((k / 4) % 2 == 1) ? 32'(8'h30 + k) : 32'(8'h20 + k));
    end
    // Reset mid-burst drops the write strobe without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);

    // FIFO full for 3 cycles after beat 2 stalls the owner without releasing it.
    do_reset();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h40;
    req1_data  = 8'h50;
    tick();
    #1;
    chk("full_b1", 32'(fifo_wr_data), 32'h40);
    tick();
    req0_data = 8'h41;
    #1;
    chk("full_b2", 32'(fifo_wr_en), 32'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      fifo_full = 1'b1;
      #1;
      chk($sformatf("full_wr_en_%0d", j), 32'(fifo_wr_en), 32'd0);
      chk($sformatf("full_ready0_%0d", j), 32'(req0_ready), 32'd0);
      chk($sformatf("full_grant_%0d", j), 32'(grant), 32'd1);
    end
    tick();
    fifo_full = 1'b0;
    req0_data = 8'h42;
    #1;
    chk("full_b3", 32'(fifo_wr_data), 32'h42);
    chk("full_b3_wr_en", 32'(fifo_wr_en), 32'd1);
    tick();
    req0_data = 8'h43;
    #1;
    chk("full_b4", 32'(fifo_wr_data), 32'h43);
    chk("full_b4_ready1", 32'(req1_ready), 32'd0);
    tick();
    #1;
    chk("full_release_grant", 32'(grant), 32'd2);
    chk("full_release_data", 32'(fifo_wr_data), 32'h50);

    // Owner 0 drops valid after one beat: ownership moves to producer 1.
    do_reset();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data  = 8'h60;
    req1_data  = 8'h70;
    tick();
    #1;
    chk("drop_b1", 32'(fifo_wr_data), 32'h60);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("drop_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("drop_grant_hold", 32'(grant), 32'd1);
    tick();
    #1;
    chk("drop_grant_switch", 32'(grant), 32'd2);
    chk("drop_p1_data", 32'(fifo_wr_data), 32'h70);

    // Producer 1 sends 300 beats back to back; its counter saturates.
    do_reset();
    tick();
    req1_valid = 1'b1;
    req1_data  = 8'h99;
    beats      = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      #1;
      if (fifo_wr_en) beats++;
    end
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    chk("sat_beats", 32'(beats), 32'd300);
`ifdef ARB_STATS_EN
    chk("sat_acc1", 32'(acc1), 32'd255);
`else
    chk("sat_acc1", 32'(acc1), 32'd0);
`endif
    chk("sat_acc0", 32'(acc0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
